fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the IF stage. Decides when and what the program counter register loads: boot vector, sequential PC+4, branch/jump redirect, or trap vector.
- Runs the single-outstanding instruction-memory handshake and holds a fetched instruction while the pipeline is stalled.
- Presents valid/instr/pc to the IF/ID register. Drives the PC register's load and pc_in inputs.

Parameters:
- RESET_VECTOR, 32'h0000_0000, address loaded into PC after reset.
- TRAP_VECTOR, 32'h0000_0100, address loaded on fetch fault.
- MAX_WAIT, 8, imem cycles without imem_ready before a timeout fault (legal range 2..255).

Ports:
- clock  in  1  clock; all state updates on falling edge, same edge as PC register.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- pc_cur  in  32  current PC register value.
- pc_load  out  1  load strobe to PC register.
- pc_next  out  32  value for PC register to load.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc_cur whenever imem_req=1, else 0).
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  hazard unit: IF/ID must not advance.
- redirect_valid  in  1  branch/jump taken in EX.
- redirect_target  in  32  redirect address.
- if_valid  out  1  IF/ID entry valid.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  PC of if_instr.
- fetch_fault  out  1  one-cycle fault pulse.
- fault_pc  out  32  faulting address, held until next fault.

Behaviour:
- Reset (async, reset=0):
  - state=BOOT, wait_cnt=0, buffer empty.
  - if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, fetch_fault=0, fault_pc=0.
  - Combinational outputs pc_load=0, imem_req=0, pc_next=RESET_VECTOR.
- States: BOOT, FETCH, HOLD, FAULT. pc_load, pc_next and imem_req are combinational from state and inputs. Everything else is registered.
- BOOT: pc_load=1, pc_next=RESET_VECTOR; next state FETCH. First imem_req is asserted one cycle after reset deasserts.
- FETCH: imem_req=1.
  - imem_ready=1 and stall=0: if_valid<=1, if_instr<=imem_rdata, if_pc<=pc_cur; pc_load=1, pc_next=pc_cur+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0); wait_cnt<=0; stay in FETCH. Back-to-back fetches give 1 instr/cycle.
  - imem_ready=1 and stall=1: capture rdata/pc into the buffer; if_* unchanged; no pc_load; go to HOLD.
  - imem_ready=0: wait_cnt++. If stall=0, if_valid<=0 (bubble). If wait_cnt==MAX_WAIT-1, go to FAULT.
- HOLD: imem_req=0. While stall=1, everything holds. When stall=0: if_valid<=1, if_instr/if_pc<=buffer; pc_load=1, pc_next=buffer_pc+4; go to FETCH.
- FAULT (one cycle): fetch_fault=1, fault_pc<=pc_cur, pc_load=1, pc_next=TRAP_VECTOR, if_valid<=0; go to FETCH.
- Any state with stall=1 and no capture: if_valid/if_instr/if_pc hold their values.
- Redirect, priority 1 (below reset only), valid in FETCH, HOLD and FAULT:
  - Flush: if_valid<=0, buffer discarded, wait_cnt<=0, state<=FETCH.
  - Any imem_ready in the same cycle is discarded.
  - Overrides stall.
  - In FAULT, redirect takes over the load but the fault pulse still fires.
  - Redirect in BOOT is ignored.
- Misaligned redirect (redirect_target[1:0]!=0): treated as a fault. pc_next=TRAP_VECTOR, fetch_fault pulses that cycle, fault_pc<=redirect_target, if_valid<=0, state FETCH.
- imem contract: imem samples imem_addr only in a cycle where it asserts imem_ready. An abandoned request (redirect/fault) needs no cancel.
- Reset mid-fetch: imem_req drops immediately (async). No pc_load until BOOT.

Decomposition:
- Package if_pkg: state enum (BOOT, FETCH, HOLD, FAULT), NOP_INSTR=32'h0000_0013, PC_STEP=4.
- Sub-module fetch_wait_timer: counter with clear/enable, terminal flag at MAX_WAIT-1, async active-low reset.

Test Plan:
- Release reset, imem_ready tied 1, stall=0 -> pc_load in BOOT with 0x0, then if_pc sequence 0x0, 0x4, 0x8 on consecutive cycles with if_valid=1.
- imem_ready low 3 cycles at PC 0x10 (MAX_WAIT=8) -> 3 bubbles (if_valid=0), then instr at 0x10, PC loads 0x14; no fault.
- imem_ready held 0 -> after 8 FETCH cycles fetch_fault pulses once, fault_pc=pc_cur, PC loads 0x100.
- Capture at 0x20 with stall=1 for 4 cycles -> state HOLD, imem_req=0, if_* frozen; stall drops -> if_pc=0x20, PC loads 0x24.
- redirect_valid with target 0x400 during stall and HOLD -> if_valid=0 next, buffer dropped, PC=0x400, next fetch at 0x400; target 0x402 -> fault, fault_pc=0x402, PC=0x100.
- PC at 0xFFFF_FFFC fetched -> pc_next=0x0; reset pulse during wait -> imem_req=0 asynchronously, then BOOT reloads 0x0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts imem cycles spent waiting for imem_ready; flags the last cycle before timeout.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [7:0] count_r;

  // Wait counter, clear has priority over enable.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage controller: PC load selection, single-outstanding imem handshake,
// stall buffering and fetch-fault reporting. State changes on the falling edge.
module fetch_sequencer
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          MAX_WAIT     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  fetch_state_e state_r;
  logic [31:0]  buf_instr_r;
  logic [31:0]  buf_pc_r;
  logic         if_valid_r;
  logic [31:0]  if_instr_r;
  logic [31:0]  if_pc_r;
  logic         fetch_fault_r;
  logic [31:0]  fault_pc_r;

  logic         redirect_s;
  logic         wait_clear_s;
  logic         wait_enable_s;
  logic         wait_done_s;
  logic         pc_load_s;
  logic [31:0]  pc_next_s;
  logic         imem_req_s;

  // A redirect in BOOT is ignored; everywhere else it wins over stall and ready.
  assign redirect_s    = redirect_valid && (state_r != BOOT);
  assign wait_enable_s = (state_r == FETCH) && !imem_ready;
  assign wait_clear_s  = (state_r != FETCH) || imem_ready || redirect_s;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (wait_clear_s),
    .enable   (wait_enable_s),
    .terminal (wait_done_s)
  );

  // PC load selection and imem request; gated by reset so they drop asynchronously.
  always_comb begin
    pc_load_s  = 1'b0;
    pc_next_s  = RESET_VECTOR;
    imem_req_s = 1'b0;
    if (!reset) begin
      pc_load_s  = 1'b0;
      imem_req_s = 1'b0;
    end else if (redirect_s) begin
      pc_load_s  = 1'b1;
      pc_next_s  = is_misaligned(redirect_target) ? TRAP_VECTOR : redirect_target;
      imem_req_s = (state_r == FETCH);
    end else begin
      case (state_r)
        BOOT: begin
          pc_load_s = 1'b1;
          pc_next_s = RESET_VECTOR;
        end
        FETCH: begin
          imem_req_s = 1'b1;
          if (imem_ready && !stall) begin
            pc_load_s = 1'b1;
            pc_next_s = pc_cur + PC_STEP;
          end else begin
            pc_load_s = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_load_s = 1'b1;
            pc_next_s = buf_pc_r + PC_STEP;
          end else begin
            pc_load_s = 1'b0;
          end
        end
        FAULT: begin
          pc_load_s = 1'b1;
          pc_next_s = TRAP_VECTOR;
        end
        default: begin
          pc_load_s = 1'b0;
        end
      endcase
    end
  end

  assign pc_load   = pc_load_s;
  assign pc_next   = pc_next_s;
  assign imem_req  = imem_req_s;
  assign imem_addr = imem_req_s ? pc_cur : 32'h0000_0000;

  // Sequencer state, stall buffer, IF/ID outputs and fault reporting.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= BOOT;
      buf_instr_r   <= NOP_INSTR;
      buf_pc_r      <= 32'h0000_0000;
      if_valid_r    <= 1'b0;
      if_instr_r    <= NOP_INSTR;
      if_pc_r       <= 32'h0000_0000;
      fetch_fault_r <= 1'b0;
      fault_pc_r    <= 32'h0000_0000;
    end else begin
      fetch_fault_r <= 1'b0;
      if (redirect_s) begin
        if_valid_r <= 1'b0;
        state_r    <= FETCH;
        if (is_misaligned(redirect_target)) begin
          fetch_fault_r <= 1'b1;
          fault_pc_r    <= redirect_target;
        end
      end else begin
        case (state_r)
          BOOT: state_r <= FETCH;
          FETCH: begin
            if (imem_ready && !stall) begin
              if_valid_r <= 1'b1;
              if_instr_r <= imem_rdata;
              if_pc_r    <= pc_cur;
            end else if (imem_ready) begin
              buf_instr_r <= imem_rdata;
              buf_pc_r    <= pc_cur;
              state_r     <= HOLD;
            end else begin
              if (!stall) begin
                if_valid_r <= 1'b0;
              end
              // Fault pulse is visible during the FAULT cycle that loads the trap vector.
              if (wait_done_s) begin
                state_r       <= FAULT;
                fetch_fault_r <= 1'b1;
                fault_pc_r    <= pc_cur;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              if_valid_r <= 1'b1;
              if_instr_r <= buf_instr_r;
              if_pc_r    <= buf_pc_r;
              state_r    <= FETCH;
            end
          end
          FAULT: begin
            if_valid_r <= 1'b0;
            state_r    <= FETCH;
          end
          default: state_r <= BOOT;
        endcase
      end
    end
  end

  assign if_valid    = if_valid_r;
  assign if_instr    = if_instr_r;
  assign if_pc       = if_pc_r;
  assign fetch_fault = fetch_fault_r;
  assign fault_pc    = fault_pc_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC register model and an imem that returns addr ^ C0DE_0000.
module tb_fetch_sequencer;

  logic        clock = 1'b1;
  logic        reset = 1'b0;
  logic [31:0] pc_cur;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_sequencer dut (
    .clock(clock), .reset(reset), .pc_cur(pc_cur), .pc_load(pc_load), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  always @(negedge clock or negedge reset) begin
    if (!reset) pc_cur <= 32'h0;
    else if (pc_load) pc_cur <= pc_next;
  end

  assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

  task automatic set_in(input logic r, input logic s, input logic rv, input logic [31:0] t);
    @(posedge clock);
    imem_ready = r; stall = s; redirect_valid = rv; redirect_target = t;
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013 || if_pc !== 32'h0 || fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin
      errors++; $display("FAIL reset_regs: got v=%b i=%h pc=%h f=%b fpc=%h want 0/00000013/0/0/0", if_valid, if_instr, if_pc, fetch_fault, fault_pc);
    end
    checks++;
    if (pc_load !== 1'b0 || imem_req !== 1'b0 || pc_next !== 32'h0) begin
      errors++; $display("FAIL reset_comb: got load=%b req=%b next=%h want 0/0/0", pc_load, imem_req, pc_next);
    end
  endtask

  task automatic test_boot_seq();
    @(posedge clock); reset = 1'b1; imem_ready = 1'b1; #1;
    checks++;
    if (pc_load !== 1'b1 || pc_next !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL boot_load: got load=%b next=%h req=%b want 1/0/0", pc_load, pc_next, imem_req);
    end
    settle();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || pc_next !== 32'(4 * i + 4) || pc_load !== 1'b1) begin
        errors++; $display("FAIL seq_req%0d: got req=%b addr=%h next=%h want 1/%h/%h", i, imem_req, imem_addr, pc_next, 4 * i, 4 * i + 4);
      end
      settle();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== (32'hC0DE_0000 | 32'(4 * i))) begin
        errors++; $display("FAIL seq_if%0d: got v=%b pc=%h i=%h want 1/%h", i, if_valid, if_pc, if_instr, 4 * i);
      end
    end
  endtask

  task automatic test_wait_bubbles();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      settle();
      checks++;
      if (if_valid !== 1'b0 || fetch_fault !== 1'b0) begin
        errors++; $display("FAIL bubble%0d: got v=%b f=%b want 0/0", i, if_valid, fetch_fault);
      end
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc_load !== 1'b1 || pc_next !== 32'h14) begin
      errors++; $display("FAIL wait_load: got load=%b next=%h want 1/00000014", pc_load, pc_next);
    end
    settle();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'hC0DE_0010 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL wait_if: got v=%b pc=%h i=%h f=%b want 1/10/C0DE0010/0", if_valid, if_pc, if_instr, fetch_fault);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      settle();
      checks++;
      if (fetch_fault !== (i == 7)) begin
        errors++; $display("FAIL timeout_pulse%0d: got %b want %b", i, fetch_fault, (i == 7));
      end
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc_load !== 1'b1 || pc_next !== 32'h100 || imem_req !== 1'b0 || fetch_fault !== 1'b1 || fault_pc !== 32'h14) begin
      errors++; $display("FAIL timeout_trap: got load=%b next=%h req=%b f=%b fpc=%h want 1/100/0/1/14", pc_load, pc_next, imem_req, fetch_fault, fault_pc);
    end
    settle();
    checks++;
    if (fetch_fault !== 1'b0 || if_valid !== 1'b0 || pc_cur !== 32'h100) begin
      errors++; $display("FAIL timeout_after: got f=%b v=%b pc=%h want 0/0/100", fetch_fault, if_valid, pc_cur);
    end
    // Redirect with ready=1 must discard the returned word.
    set_in(1'b1, 1'b0, 1'b1, 32'h20);
    checks++;
    if (pc_load !== 1'b1 || pc_next !== 32'h20) begin
      errors++; $display("FAIL redir_load: got load=%b next=%h want 1/20", pc_load, pc_next);
    end
    settle();
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h10) begin
      errors++; $display("FAIL redir_discard: got v=%b pc=%h want 0/10", if_valid, if_pc);
    end
  endtask

  task automatic test_hold();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (pc_load !== 1'b0 || imem_addr !== 32'h20) begin
      errors++; $display("FAIL capture: got load=%b addr=%h want 0/20", pc_load, imem_addr);
    end
    settle();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_load !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h10) begin
        errors++; $display("FAIL hold%0d: got req=%b addr=%h load=%b v=%b pc=%h want 0/0/0/0/10", i, imem_req, imem_addr, pc_load, if_valid, if_pc);
      end
      settle();
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc_load !== 1'b1 || pc_next !== 32'h24) begin
      errors++; $display("FAIL release_load: got load=%b next=%h want 1/24", pc_load, pc_next);
    end
    settle();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instr !== 32'hC0DE_0020) begin
      errors++; $display("FAIL release_if: got v=%b pc=%h i=%h want 1/20/C0DE0020", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    settle();
    set_in(1'b1, 1'b1, 1'b1, 32'h400);
    checks++;
    if (pc_load !== 1'b1 || pc_next !== 32'h400) begin
      errors++; $display("FAIL hold_redir: got load=%b next=%h want 1/400", pc_load, pc_next);
    end
    settle();
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL hold_flush: got v=%b want 0", if_valid);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h400 || pc_next !== 32'h404) begin
      errors++; $display("FAIL redir_fetch: got addr=%h next=%h want 400/404", imem_addr, pc_next);
    end
    settle();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instr !== 32'hC0DE_0400) begin
      errors++; $display("FAIL redir_if: got v=%b pc=%h i=%h want 1/400/C0DE0400", if_valid, if_pc, if_instr);
    end
    set_in(1'b1, 1'b1, 1'b1, 32'h402);
    checks++;
    if (pc_load !== 1'b1 || pc_next !== 32'h100) begin
      errors++; $display("FAIL misalign_load: got load=%b next=%h want 1/100", pc_load, pc_next);
    end
    settle();
    checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h402 || if_valid !== 1'b0 || if_pc !== 32'h400) begin
      errors++; $display("FAIL misalign_fault: got f=%b fpc=%h v=%b pc=%h want 1/402/0/400", fetch_fault, fault_pc, if_valid, if_pc);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h100 || pc_load !== 1'b0) begin
      errors++; $display("FAIL misalign_next: got addr=%h load=%b want 100/0", imem_addr, pc_load);
    end
    settle();
    checks++;
    if (fetch_fault !== 1'b0 || fault_pc !== 32'h402) begin
      errors++; $display("FAIL misalign_once: got f=%b fpc=%h want 0/402", fetch_fault, fault_pc);
    end
  endtask

  task automatic test_wrap_and_reset();
    set_in(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    settle();
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || pc_load !== 1'b1 || pc_next !== 32'h0) begin
      errors++; $display("FAIL wrap_next: got addr=%h load=%b next=%h want FFFFFFFC/1/0", imem_addr, pc_load, pc_next);
    end
    settle();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h3F21_FFFC) begin
      errors++; $display("FAIL wrap_if: got v=%b pc=%h i=%h want 1/FFFFFFFC/3F21FFFC", if_valid, if_pc, if_instr);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL pre_reset_req: got %b want 1", imem_req);
    end
    #1; reset = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b0 || pc_load !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got req=%b load=%b v=%b want 0/0/0", imem_req, pc_load, if_valid);
    end
    settle();
    @(posedge clock); reset = 1'b1; #1;
    checks++;
    if (pc_load !== 1'b1 || pc_next !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL reboot_load: got load=%b next=%h req=%b want 1/0/0", pc_load, pc_next, imem_req);
    end
    settle();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reboot_fetch: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_wait_bubbles();
    test_timeout();
    test_hold();
    test_redirect();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
